// File: rtl/and_reduce_pipe.sv
// and_reduce_pipe: pipelined N_IN-bit reduction (AND / OR / XOR / NAND) built as a
// registered GROUP-ary tree. Each stage carries its beat's mode alongside the partials,
// and an elastic valid/ready chain lets the pipeline fill under stall without bubbles.
module and_reduce_pipe #(
    parameter int unsigned N_IN  = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] in_data,
    input  logic [1:0]      in_mode,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);

    // Smallest k >= 1 with g^k >= n.
    function automatic int unsigned calc_lat(input int unsigned n, input int unsigned g);
        int unsigned k;
        int unsigned span;
        k    = 1;
        span = g;
        while (span < n) begin
            span = span * g;
            k++;
        end
        return k;
    endfunction

    function automatic int unsigned ipow(input int unsigned base, input int unsigned e);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < e; i++) begin
            r = r * base;
        end
        return r;
    endfunction

    localparam int unsigned LAT    = calc_lat(N_IN, GROUP);
    localparam int unsigned LEAVES = ipow(GROUP, LAT);

    localparam logic [1:0] MODE_AND  = 2'd0;
    localparam logic [1:0] MODE_OR   = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_NAND = 2'd3;

    // NAND shares the AND node; its inversion happens only at the final register.
    function automatic logic node(input logic [GROUP-1:0] g, input logic [1:0] mode);
        case (mode)
            MODE_OR:  return |g;
            MODE_XOR: return ^g;
            default:  return &g;
        endcase
    endfunction

    logic [LEAVES-1:0] leaf;
    logic [LAT-1:0]    valid_vec;
    logic [LAT-1:0]    ready_vec;
    logic              ready_run;

    // Pad unused leaves with the identity of the incoming beat's mode.
    always_comb begin
        leaf           = {LEAVES{(in_mode == MODE_AND) || (in_mode == MODE_NAND)}};
        leaf[N_IN-1:0] = in_data;
    end

    // A stage can load when it is empty or every stage after it can move on.
    always_comb begin
        ready_vec = '0;
        ready_run = out_ready;
        for (int k = int'(LAT) - 1; k >= 0; k--) begin
            ready_run    = ready_run || !valid_vec[k];
            ready_vec[k] = ready_run;
        end
    end

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        localparam int unsigned W    = ipow(GROUP, LAT - 1 - k);
        localparam bit          LAST = (k == LAT - 1);

        logic [W*GROUP-1:0] src;
        logic [1:0]         src_mode;
        logic               src_valid;
        logic [W-1:0]       red;
        logic [W-1:0]       part_q;
        logic               valid_q;

        if (k == 0) begin : g_src
            assign src       = leaf;
            assign src_mode  = in_mode;
            assign src_valid = in_valid;
        end else begin : g_src
            assign src       = g_stage[k-1].part_q;
            assign src_mode  = g_stage[k-1].g_mode.mode_q;
            assign src_valid = g_stage[k-1].valid_q;
        end

        // One tree level: each output partial reduces GROUP neighbouring inputs.
        always_comb begin
            red = '0;
            for (int j = 0; j < int'(W); j++) begin
                red[j] = node(src[j*GROUP +: GROUP], src_mode);
            end
        end

        // Stage valid and partials advance together; data only loads with a real beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                part_q  <= '0;
            end else if (ready_vec[k]) begin
                valid_q <= src_valid;
                if (src_valid) begin
                    part_q <= red ^ {W{LAST && (src_mode == MODE_NAND)}};
                end
            end
        end

        // The final stage has already applied the mode, so only inner stages keep it.
        if (!LAST) begin : g_mode
            logic [1:0] mode_q;

            // Mode travels with its beat into the next level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mode_q <= MODE_AND;
                end else if (ready_vec[k] && src_valid) begin
                    mode_q <= src_mode;
                end
            end
        end

        assign valid_vec[k] = valid_q;
    end

    assign in_ready  = ready_vec[0];
    assign out_valid = valid_vec[LAT-1];
    assign out1      = g_stage[LAT-1].part_q[0];
    assign busy      = |valid_vec;

endmodule

// File: tb/tb_and_reduce_pipe.sv
// Bench for and_reduce_pipe: table-driven single beats on 16/4 and 10/4 instances,
// hand-written back-to-back, backpressure and mid-flight reset sequences, then
// randomised traffic on several N_IN/GROUP configurations against a reference queue.
module tb_and_reduce_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    bit   rand_go = 1'b0;
    int   rand_done = 0;

    // 16-bit, GROUP 4 instance
    logic [15:0] a_data;
    logic [1:0]  a_mode;
    logic        a_valid, a_in_ready, a_out1, a_out_valid, a_out_ready, a_busy;

    // 10-bit, GROUP 4 instance (padded leaves)
    logic [9:0]  b_data;
    logic [1:0]  b_mode;
    logic        b_valid, b_in_ready, b_out1, b_out_valid, b_out_ready, b_busy;

    and_reduce_pipe #(.N_IN(16), .GROUP(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_mode(a_mode), .in_valid(a_valid),
        .in_ready(a_in_ready), .out1(a_out1), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .busy(a_busy)
    );

    and_reduce_pipe #(.N_IN(10), .GROUP(4)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_mode(b_mode), .in_valid(b_valid),
        .in_ready(b_in_ready), .out1(b_out1), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .busy(b_busy)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] data;
        logic        exp;
    } vec_t;

    vec_t v16[8];
    vec_t v10[6];
    vec_t bb[4];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic ref_red(input logic [63:0] d, input int unsigned n,
                                     input logic [1:0] m);
        logic r;
        r = (m == 2'd1 || m == 2'd2) ? 1'b0 : 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            case (m)
                2'd1:    r = r | d[i];
                2'd2:    r = r ^ d[i];
                default: r = r & d[i];
            endcase
        end
        return (m == 2'd3) ? ~r : r;
    endfunction

    // Single isolated beat with out_ready high: checks accept, 2-cycle latency, result, drain.
    task automatic beat(input bit sel10, input logic [1:0] m, input logic [15:0] d,
                        input logic e, input string name);
        @(negedge clk);
        if (sel10) begin
            b_mode = m; b_data = d[9:0]; b_valid = 1'b1;
        end else begin
            a_mode = m; a_data = d; a_valid = 1'b1;
        end
        #1 chk({name, " in_ready"}, sel10 ? b_in_ready : a_in_ready, 1'b1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk({name, " early"}, sel10 ? b_out_valid : a_out_valid, 1'b0);
        @(posedge clk); #1;
        chk({name, " out_valid"}, sel10 ? b_out_valid : a_out_valid, 1'b1);
        chk({name, " out1"}, sel10 ? b_out1 : a_out1, e);
        @(posedge clk); #1;
        chk({name, " drained"}, sel10 ? b_out_valid : a_out_valid, 1'b0);
    endtask

    function automatic int unsigned cfg_n(input int i);
        case (i)
            0:       return 2;
            1:       return 5;
            2:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int unsigned cfg_g(input int i);
        return (i < 2) ? 2 : 4;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int unsigned N = cfg_n(g);
        localparam int unsigned G = cfg_g(g);

        logic [N-1:0] din;
        logic [1:0]   mode;
        logic         iv, ir, o1, ov, ordy, bsy;
        logic         exp_q[$];

        and_reduce_pipe #(.N_IN(N), .GROUP(G)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_data(din), .in_mode(mode), .in_valid(iv),
            .in_ready(ir), .out1(o1), .out_valid(ov), .out_ready(ordy), .busy(bsy)
        );

        initial begin
            logic [63:0] d64;
            logic        e;
            din  = '0;
            mode = 2'd0;
            iv   = 1'b0;
            ordy = 1'b0;
            d64  = '0;
            wait (rand_go);
            for (int c = 0; c < 420; c++) begin
                @(negedge clk);
                if (c < 400) begin
                    d64  = {$urandom(), $urandom()};
                    din  = d64[N-1:0];
                    mode = 2'($urandom_range(0, 3));
                    iv   = ($urandom_range(0, 3) != 0);
                    ordy = ($urandom_range(0, 3) != 0);
                end else begin
                    iv   = 1'b0;
                    ordy = 1'b1;
                end
                #1;
                if (ov && ordy) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("rand%0d spurious out_valid", g), ov, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("rand%0d out1", g), o1, e);
                    end
                end
                if (iv && ir) exp_q.push_back(ref_red(d64, N, mode));
            end
            chk($sformatf("rand%0d all delivered", g), exp_q.size() == 0, 1'b1);
            chk($sformatf("rand%0d idle busy", g), bsy, 1'b0);
            rand_done++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v16[0] = '{2'd0, 16'hFFFF, 1'b1};
        v16[1] = '{2'd0, 16'hFFFE, 1'b0};
        v16[2] = '{2'd1, 16'h0000, 1'b0};
        v16[3] = '{2'd1, 16'h0100, 1'b1};
        v16[4] = '{2'd2, 16'h0007, 1'b1};
        v16[5] = '{2'd2, 16'h8001, 1'b0};
        v16[6] = '{2'd3, 16'hFFFF, 1'b0};
        v16[7] = '{2'd3, 16'h7FFF, 1'b1};

        v10[0] = '{2'd0, 16'h03FF, 1'b1};
        v10[1] = '{2'd1, 16'h0000, 1'b0};
        v10[2] = '{2'd2, 16'h0200, 1'b1};
        v10[3] = '{2'd3, 16'h03FF, 1'b0};
        v10[4] = '{2'd0, 16'h01FF, 1'b0};
        v10[5] = '{2'd2, 16'h03FF, 1'b0};

        bb[0] = '{2'd1, 16'h0000, 1'b0};
        bb[1] = '{2'd2, 16'h0007, 1'b1};
        bb[2] = '{2'd3, 16'hFFFF, 1'b0};
        bb[3] = '{2'd2, 16'h8001, 1'b0};

        rst_n = 1'b0;
        a_data = '0; a_mode = 2'd0; a_valid = 1'b0; a_out_ready = 1'b1;
        b_data = '0; b_mode = 2'd0; b_valid = 1'b0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", a_out_valid, 1'b0);
        chk("reset out1", a_out1, 1'b0);
        chk("reset busy", a_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post-reset in_ready", a_in_ready, 1'b1);

        for (int i = 0; i < 8; i++) beat(1'b0, v16[i].mode, v16[i].data, v16[i].exp,
                                         $sformatf("v16[%0d]", i));
        for (int i = 0; i < 6; i++) beat(1'b1, v10[i].mode, v10[i].data, v10[i].exp,
                                         $sformatf("v10[%0d]", i));

        // Back-to-back: one beat per cycle, results on consecutive cycles.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) begin
                a_mode = bb[c].mode; a_data = bb[c].data; a_valid = 1'b1;
                #1 chk($sformatf("b2b in_ready %0d", c), a_in_ready, 1'b1);
            end else begin
                a_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (c >= 1 && c <= 4) begin
                chk($sformatf("b2b out_valid %0d", c - 1), a_out_valid, 1'b1);
                chk($sformatf("b2b out1 %0d", c - 1), a_out1, bb[c-1].exp);
            end else if (c == 5) begin
                chk("b2b drained", a_out_valid, 1'b0);
            end
        end

        // Backpressure: two beats fill the pipe, the third is refused.
        @(negedge clk);
        a_out_ready = 1'b0; a_mode = 2'd0; a_data = 16'hFFFF; a_valid = 1'b1;
        #1 chk("bp accept0", a_in_ready, 1'b1);
        @(posedge clk); #1;
        a_mode = 2'd1; a_data = 16'h0000;
        chk("bp ov after 1", a_out_valid, 1'b0);
        @(negedge clk); #1 chk("bp accept1", a_in_ready, 1'b1);
        @(posedge clk); #1;
        a_mode = 2'd2; a_data = 16'h0001;
        chk("bp ov after 2", a_out_valid, 1'b1);
        chk("bp out1 A", a_out1, 1'b1);
        repeat (3) begin
            @(negedge clk); #1;
            chk("bp full in_ready", a_in_ready, 1'b0);
            chk("bp stall out_valid", a_out_valid, 1'b1);
            chk("bp stall out1", a_out1, 1'b1);
            chk("bp stall busy", a_busy, 1'b1);
        end
        @(negedge clk);
        a_valid = 1'b0; a_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp out_valid B", a_out_valid, 1'b1);
        chk("bp out1 B", a_out1, 1'b0);
        @(posedge clk); #1;
        chk("bp empty out_valid", a_out_valid, 1'b0);
        chk("bp empty in_ready", a_in_ready, 1'b1);
        chk("bp empty busy", a_busy, 1'b0);

        // Reset with two beats in flight.
        @(negedge clk);
        a_out_ready = 1'b0; a_mode = 2'd0; a_data = 16'hFFFF; a_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        a_valid = 1'b0;
        chk("rst pre busy", a_busy, 1'b1);
        chk("rst pre out_valid", a_out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst async out_valid", a_out_valid, 1'b0);
        chk("rst async busy", a_busy, 1'b0);
        chk("rst async out1", a_out1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst no ghost out_valid", a_out_valid, 1'b0);
        end
        beat(1'b0, 2'd2, 16'h0003, 1'b0, "post rst beat");

        // Randomised traffic on the configuration sweep.
        rand_go = 1'b1;
        for (int t = 0; t < 2000 && rand_done < 4; t++) @(posedge clk);
        chk("random phase completed", rand_done == 4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/and_reduce_pipe.md
Name: and_reduce_pipe

Overview:
- Parametrised, pipelined successor to the fixed 4-input AND gate.
- Reduces an N_IN-bit input vector to one bit per beat using a runtime-selected mode: AND, OR, XOR or NAND.
- Uses a registered reduction tree with valid/ready handshakes on both sides.
- Sits between combinational condition-generation logic and flop-based consumers, so wide reductions are pipelined instead of being a single long combinational path.

Parameters:
- N_IN, 16, number of input bits reduced per beat; legal range 2..256.
- GROUP, 4, fan-in of each tree node per stage; legal range 2..8.
- LAT, derived (not overridable): number of pipeline stages = smallest k ≥ 1 with GROUP^k ≥ N_IN. Defaults give LAT = 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N_IN  operand vector; bit i is input i.
- in_mode  input  2  operation select: 0 = AND, 1 = OR, 2 = XOR, 3 = NAND.
- in_valid  input  1  beat present on in_data/in_mode.
- in_ready  output  1  block accepts the beat this cycle.
- out1  output  1  reduction result.
- out_valid  output  1  out1 holds a valid result.
- out_ready  input  1  downstream consumes out1 this cycle.
- busy  output  1  any pipeline stage holds a valid beat.

Behaviour:
- Reset is asynchronous on rst_n low. It clears every stage valid bit, every partial result and every stored mode.
  - Reset values: out_valid = 0, out1 = 0, busy = 0.
  - in_ready = 1 combinationally once reset is released.
- Accept condition: in_valid && in_ready at a rising edge. in_data and in_mode are captured together; the mode travels with its beat through every stage.
- Stage structure:
  - Stage 0 reduces groups of GROUP input bits.
  - Stage k (k ≥ 1) reduces groups of GROUP stage k-1 partials.
  - The final stage produces one bit.
  - Each stage register holds: partial results, mode, valid.
- Padding: unused leaf positions, when N_IN is not a power of GROUP, take the identity value for the beat's mode. Identity is 1 for AND/NAND and 0 for OR/XOR. Padding must never change the result.
- Node function:
  - Modes AND and NAND use an AND node.
  - Mode OR uses an OR node.
  - Mode XOR uses an XOR node.
  - NAND inverts only at the final stage output register.
- Flow control: elastic pipeline with no bubbles under continuous flow.
  - Final stage advances when !out_valid || out_ready.
  - Stage k advances when its successor is empty or advancing.
  - in_ready = stage 0 empty || stage 0 advancing. This is a combinational path from out_ready through the stage chain.
- Latency and throughput: a beat accepted at edge t appears with out_valid = 1 after edge t+LAT-1, i.e. LAT cycles, when no stall occurs. Throughput is 1 beat/cycle.
- Stall: while out_valid && !out_ready, out1 stays stable and upstream stages fill.
  - With all LAT stages full, in_ready = 0.
  - At most LAT beats are held; none are dropped or duplicated.
- Simultaneous events: on the same edge, the final stage may be consumed and a new beat accepted at stage 0; the pipeline shifts by one.
- Mode changes between consecutive beats are legal. Each result uses only its own beat's mode.
- in_data/in_mode are ignored when in_valid = 0, and also when in_ready = 0.
- Reset mid-operation: all in-flight beats are discarded. No out_valid pulse occurs after rst_n is deasserted until a new beat is accepted.
- busy = OR of all stage valid bits.
- Results appear strictly in acceptance order.

Test Plan:
- Reset then single beat, N_IN = 16, GROUP = 4, mode 0, in_data = 16'hFFFF, out_ready = 1 -> out_valid high 2 cycles after accept, out1 = 1. Repeat with 16'hFFFE -> out1 = 0.
- Back-to-back beats, one per cycle, out_ready = 1: modes 1 / 16'h0000, 2 / 16'h0007, 3 / 16'hFFFF, 2 / 16'h8001 -> out1 sequence 0, 1, 0, 0 on consecutive cycles with out_valid continuously high.
- Backpressure: hold out_ready = 0, push beats -> exactly 2 accepted, then in_ready = 0 and out1 stable. Release out_ready -> both results delivered in order, then in_ready = 1.
- Non-power padding, N_IN = 10, GROUP = 4 (LAT = 2): mode 0 with 10'h3FF -> 1; mode 1 with 10'h000 -> 0; mode 2 with 10'h200 -> 1.
- Assert rst_n low with 2 beats in flight -> out_valid = 0 and busy = 0 immediately. After release, no output appears until a new beat is accepted.
- Randomised data/mode/valid/ready, N_IN in {2, 5, 16, 64}, GROUP in {2, 4}, compared against a reference queue -> no loss, no duplication, no mismatch.
